// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK flip-flop command sequencer.
package jk_seq_pkg;

    // Command encodings, {j,k}
    typedef enum logic [1:0] {
        CMD_HOLD   = 2'b00,
        CMD_RESET  = 2'b01,
        CMD_SET    = 2'b10,
        CMD_TOGGLE = 2'b11
    } cmd_e;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_APPLY = 2'b01,
        ST_CHECK = 2'b10
    } state_e;

    localparam int CMD_W = 2;

    // FIFO entry is {cmd, hold}
    function automatic int entry_w(input int hold_w);
        return CMD_W + hold_w;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty discrimination.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push_en;
    logic             pop_en;

    // Full when the index bits match but the wrap bits differ
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_en = i_push && !o_full;
    assign pop_en  = i_pop && !o_empty;
    assign o_rdata = mem[rd_ptr_q[AW-1:0]];

    // Pointer update; reset flushes the FIFO
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since empty gates reads
    always_ff @(posedge i_clk) begin
        if (push_en) mem[wr_ptr_q[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers JK commands, drives o_j/o_k for the requested length, then checks
// the flip-flop output against an expected-state model.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | nothing in flight; pops the FIFO head when one is present
// ST_APPLY | o_j/o_k driven with the command; down-counter runs to zero
// ST_CHECK | one 0/0 cycle; compare i_q, count, pop next or go idle
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    input  logic [HOLD_W-1:0] i_cmd_hold,
    output logic              o_cmd_ready,
    output logic              o_j,
    output logic              o_k,
    input  logic              i_q,
    output logic              o_busy,
    output logic              o_err,
    output logic [7:0]        o_done_cnt
);
    localparam int ENTRY_W = entry_w(HOLD_W);

    state_e             state_q;
    state_e             state_d;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop_req;
    logic               load;
    logic               enter_check;
    logic               cnt_dec;
    logic               check_done;

    logic [1:0]         head_cmd;
    logic [HOLD_W-1:0]  head_hold;
    logic [HOLD_W-1:0]  head_cnt;
    logic               head_n_odd;

    cmd_e               cmd_q;
    logic [HOLD_W-1:0]  cnt_q;
    logic               n_odd_q;
    logic               exp_q;
    logic               exp_valid_q;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_cmd_valid),
        .i_wdata ({i_cmd, i_cmd_hold}),
        .i_pop   (pop_req),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Hold 0 behaves as 1; the counter holds N-1 so terminal count is zero
    assign head_cmd   = fifo_rdata[ENTRY_W-1 -: 2];
    assign head_hold  = fifo_rdata[HOLD_W-1:0];
    assign head_cnt   = (head_hold == '0) ? '0 : head_hold - HOLD_W'(1);
    assign head_n_odd = (head_hold == '0) ? 1'b1 : head_hold[0];

    assign o_cmd_ready = !fifo_full;
    assign o_busy      = (state_q != ST_IDLE) || !fifo_empty;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and control strobes
    always_comb begin
        state_d     = state_q;
        pop_req     = 1'b0;
        load        = 1'b0;
        enter_check = 1'b0;
        cnt_dec     = 1'b0;
        check_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_req = 1'b1;
                    load    = 1'b1;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (cnt_q == '0) begin
                    enter_check = 1'b1;
                    state_d     = ST_CHECK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_CHECK: begin
                check_done = 1'b1;
                if (!fifo_empty) begin
                    pop_req = 1'b1;
                    load    = 1'b1;
                    state_d = ST_APPLY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch, drive outputs and down-counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cmd_q   <= CMD_HOLD;
            cnt_q   <= '0;
            n_odd_q <= 1'b0;
            o_j     <= 1'b0;
            o_k     <= 1'b0;
        end else if (load) begin
            cmd_q   <= cmd_e'(head_cmd);
            cnt_q   <= head_cnt;
            n_odd_q <= head_n_odd;
            o_j     <= head_cmd[1];
            o_k     <= head_cmd[0];
        end else if (enter_check) begin
            o_j     <= 1'b0;
            o_k     <= 1'b0;
        end else if (cnt_dec) begin
            cnt_q   <= cnt_q - HOLD_W'(1);
        end
    end

    // Expected flip-flop state, advanced as each command finishes applying
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            exp_q       <= 1'b0;
            exp_valid_q <= 1'b0;
        end else if (enter_check) begin
            case (cmd_q)
                CMD_SET: begin
                    exp_q       <= 1'b1;
                    exp_valid_q <= 1'b1;
                end
                CMD_RESET: begin
                    exp_q       <= 1'b0;
                    exp_valid_q <= 1'b1;
                end
                CMD_TOGGLE: exp_q <= exp_q ^ n_odd_q;
                default: ;
            endcase
        end
    end

    // Completion count and sticky mismatch flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_done_cnt <= '0;
            o_err      <= 1'b0;
        end else if (check_done) begin
            o_done_cnt <= o_done_cnt + 8'd1;
            if (exp_valid_q && (i_q != exp_q)) o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer with a behavioural JK flip-flop in the loop and
// a timeline-based reference model of the sequencer.
module tb_jk_cmd_sequencer;
    localparam int DEPTH  = 4;
    localparam int HOLD_W = 4;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_cmd_valid = 1'b0;
    logic [1:0]        i_cmd = 2'b00;
    logic [HOLD_W-1:0] i_cmd_hold = '0;
    logic              i_q;
    logic              o_cmd_ready, o_j, o_k, o_busy, o_err;
    logic [7:0]        o_done_cnt;

    jk_cmd_sequencer #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd       (i_cmd),
        .i_cmd_hold  (i_cmd_hold),
        .o_cmd_ready (o_cmd_ready),
        .o_j         (o_j),
        .o_k         (o_k),
        .i_q         (i_q),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_done_cnt  (o_done_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural JK flip-flop; inject forces the feedback low
    logic ff_q = 1'b0;
    logic inject = 1'b0;
    assign i_q = inject ? 1'b0 : ff_q;
    always @(posedge i_clk) begin
        case ({o_j, o_k})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a command popped at edge s with length n drives j/k
    // after edges s..s+n-1, is idle after s+n, and completes at edge s+n+1.
    typedef struct { logic [1:0] c; int n; } mcmd_t;
    mcmd_t mq[$];
    mcmd_t head;
    bit    model_on = 0;
    bit    m_active = 0;
    int    m_start, m_n, m_done_edge;
    logic [1:0] m_cmd;
    bit    m_exp_q = 0, m_exp_valid = 0, m_err = 0;
    int    m_done = 0;
    int    edge_i = 0;
    logic  pre_q;
    int    pre_size;
    bit    e_j = 0, e_k = 0, e_busy = 0, e_ready = 1;

    always @(posedge i_clk) begin
        pre_q    = i_q;
        pre_size = mq.size();
        edge_i++;
        if (i_rst) begin
            mq.delete();
            m_active    = 0;
            m_exp_q     = 0;
            m_exp_valid = 0;
            m_err       = 0;
            m_done      = 0;
            model_on    = 1;
        end else begin
            if (m_active && edge_i == m_done_edge) begin
                case (m_cmd)
                    2'b10: begin m_exp_q = 1; m_exp_valid = 1; end
                    2'b01: begin m_exp_q = 0; m_exp_valid = 1; end
                    2'b11: if (m_n % 2 == 1) m_exp_q = !m_exp_q;
                    default: ;
                endcase
                if (m_exp_valid && (pre_q != m_exp_q)) m_err = 1;
                m_done   = (m_done + 1) % 256;
                m_active = 0;
            end
            if (!m_active && pre_size > 0) begin
                head        = mq.pop_front();
                m_active    = 1;
                m_start     = edge_i;
                m_cmd       = head.c;
                m_n         = head.n;
                m_done_edge = edge_i + m_n + 1;
            end
            if (i_cmd_valid && pre_size < DEPTH) begin
                head.c = i_cmd;
                head.n = (i_cmd_hold == '0) ? 1 : int'(i_cmd_hold);
                mq.push_back(head);
            end
        end
        e_j     = m_active && (edge_i - m_start) < m_n && m_cmd[1];
        e_k     = m_active && (edge_i - m_start) < m_n && m_cmd[0];
        e_busy  = m_active || (mq.size() > 0);
        e_ready = mq.size() < DEPTH;
    end

    // Every-cycle comparison against the model
    always @(negedge i_clk) begin
        if (model_on) begin
            check("o_j", {7'd0, o_j}, {7'd0, e_j});
            check("o_k", {7'd0, o_k}, {7'd0, e_k});
            check("o_busy", {7'd0, o_busy}, {7'd0, e_busy});
            check("o_cmd_ready", {7'd0, o_cmd_ready}, {7'd0, e_ready});
            check("o_err", {7'd0, o_err}, {7'd0, m_err});
            check("o_done_cnt", o_done_cnt, m_done[7:0]);
        end
    end

    int jk11 = 0;
    always @(negedge i_clk) if (o_j && o_k) jk11++;

    // Present a command and keep valid high until it is accepted
    task automatic push(input logic [1:0] c, input int h);
        bit acc;
        int n;
        n = 0;
        i_cmd       = c;
        i_cmd_hold  = HOLD_W'(h);
        i_cmd_valid = 1'b1;
        do begin
            acc = o_cmd_ready;
            @(negedge i_clk);
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: ready 0 expected 1 within 100 cycles");
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (o_busy && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        if (o_busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy 1 expected 0 within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        i_cmd_valid = 1'b0;
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        // Reset values
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        check("rst_j", {7'd0, o_j}, 8'd0);
        check("rst_k", {7'd0, o_k}, 8'd0);
        check("rst_busy", {7'd0, o_busy}, 8'd0);
        check("rst_err", {7'd0, o_err}, 8'd0);
        check("rst_done", o_done_cnt, 8'd0);
        check("rst_ready", {7'd0, o_cmd_ready}, 8'd1);
        i_rst = 1'b0;

        // Set then toggle
        jk11 = 0;
        push(2'b10, 1);
        push(2'b11, 3);
        i_cmd_valid = 1'b0;
        wait_idle(100);
        check("st_jk11_cycles", jk11[7:0], 8'd3);
        check("st_final_q", {7'd0, i_q}, 8'd0);
        check("st_err", {7'd0, o_err}, 8'd0);
        check("st_done", o_done_cnt, 8'd2);

        // Fill and backpressure behind a hold-15 command
        push(2'b10, 15);
        push(2'b01, 1);
        push(2'b10, 2);
        push(2'b11, 1);
        push(2'b00, 3);
        check("bp_ready_low", {7'd0, o_cmd_ready}, 8'd0);
        check("bp_stalled_done", o_done_cnt, 8'd2);
        push(2'b11, 2);
        check("bp_fifth_after_pop", o_done_cnt, 8'd3);
        i_cmd_valid = 1'b0;
        wait_idle(200);
        check("bp_done", o_done_cnt, 8'd8);
        check("bp_err", {7'd0, o_err}, 8'd0);

        // Error injection, then sticky through passing commands
        inject = 1'b1;
        push(2'b10, 2);
        i_cmd_valid = 1'b0;
        wait_idle(100);
        check("inj_err_set", {7'd0, o_err}, 8'd1);
        inject = 1'b0;
        push(2'b01, 1);
        push(2'b10, 1);
        i_cmd_valid = 1'b0;
        wait_idle(100);
        check("inj_err_sticky", {7'd0, o_err}, 8'd1);
        check("inj_done", o_done_cnt, 8'd11);

        // Hold 0 toggle right after reset: one cycle, unchecked
        do_reset();
        jk11 = 0;
        push(2'b11, 0);
        i_cmd_valid = 1'b0;
        wait_idle(100);
        check("h0_jk11_cycles", jk11[7:0], 8'd1);
        check("h0_err", {7'd0, o_err}, 8'd0);
        check("h0_done", o_done_cnt, 8'd1);

        // Reset in the middle of a hold-10 command with two queued
        push(2'b10, 10);
        push(2'b01, 1);
        push(2'b11, 2);
        i_cmd_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("mid_rst_j", {7'd0, o_j}, 8'd0);
        check("mid_rst_k", {7'd0, o_k}, 8'd0);
        check("mid_rst_busy", {7'd0, o_busy}, 8'd0);
        check("mid_rst_done", o_done_cnt, 8'd0);
        check("mid_rst_ready", {7'd0, o_cmd_ready}, 8'd1);
        i_rst = 1'b0;

        // Randomized traffic; occasional forced feedback in the second half
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 3)) begin
                i_cmd_valid = 1'b0;
                @(negedge i_clk);
            end
            inject = (i >= 40) && ($urandom_range(0, 7) == 0);
            push(2'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
            if (i == 39) begin
                i_cmd_valid = 1'b0;
                wait_idle(200);
                check("rand_no_err", {7'd0, o_err}, 8'd0);
            end
        end
        i_cmd_valid = 1'b0;
        inject = 1'b0;
        wait_idle(2000);
        @(negedge i_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
